// File: rtl/div_out_monitor.sv
// Measures period and high time of a divided clock in clk cycles and checks them against an expected period.
// Latency: 3 clk edges from a div_in edge to detection; results register one edge after the closing rise. No backpressure.
module div_out_monitor #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic [CNT_W-1:0] expected_period,
  input  logic             clear,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             valid,
  output logic             locked,
  output logic             err_sticky,
  output logic             stuck
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int              MC_W     = 4;
  localparam logic [MC_W-1:0] LOCK_VAL = MC_W'(LOCK_COUNT);
  localparam logic [CNT_W:0]  TOL_VAL  = (CNT_W+1)'(TOL);

  state_t           state;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [MC_W-1:0]  match_cnt;
  logic [MC_W-1:0]  match_inc;
  logic [CNT_W:0]   cnt_ext, exp_ext, diff;
  logic             match;
  logic             cnt_full;

  // div_in is asynchronous; s3 only provides edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= div_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign cnt_full = &cnt;

  // Absolute difference one bit wider than the counter so it cannot wrap
  always_comb begin
    cnt_ext = {1'b0, cnt};
    exp_ext = {1'b0, expected_period};
    diff    = (cnt_ext >= exp_ext) ? (cnt_ext - exp_ext) : (exp_ext - cnt_ext);
  end

  assign match     = (diff <= TOL_VAL);
  assign match_inc = (match_cnt == LOCK_VAL) ? match_cnt : match_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_cnt     <= '0;
      match_cnt  <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      err_sticky <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        cnt        <= '0;
        match_cnt  <= '0;
        locked     <= 1'b0;
        err_sticky <= 1'b0;
        stuck      <= 1'b0;
      end else begin
        if (rise) begin
          cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (!cnt_full) begin
          cnt <= cnt + 1'b1;
        end

        if (rise) begin
          stuck <= 1'b0;
          case (state)
            IDLE: state <= HIGH;
            LOW: begin
              state      <= HIGH;
              period_out <= cnt;
              high_out   <= hi_cnt;
              valid      <= 1'b1;
              if (match) begin
                match_cnt <= match_inc;
                locked    <= (match_inc == LOCK_VAL);
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
                if (locked) begin
                  err_sticky <= 1'b1;
                end
              end
            end
            // A rise while still high means a glitch got through; re-arm
            default: state <= IDLE;
          endcase
        end else if (cnt_full && (state != IDLE)) begin
          stuck     <= 1'b1;
          locked    <= 1'b0;
          match_cnt <= '0;
          state     <= IDLE;
        end else if (fall && (state == HIGH)) begin
          hi_cnt <= cnt;
          state  <= LOW;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_out_monitor.sv
// Bench for div_out_monitor: directed div_in waveforms, expected results queued per closing period.
module tb_div_out_monitor;

  localparam int CNT_W = 4;

  typedef struct {
    int p;
    int h;
    int lk;
    int er;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             div_in;
  logic [CNT_W-1:0] expected_period;
  logic             clear;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             valid;
  logic             locked;
  logic             err_sticky;
  logic             stuck;

  exp_t exp_q[$];
  exp_t e_cur;
  int   tests = 0;
  int   fails = 0;
  int   vcount = 0;

  div_out_monitor #(
    .CNT_W(CNT_W),
    .LOCK_COUNT(4),
    .TOL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .div_in(div_in),
    .expected_period(expected_period),
    .clear(clear),
    .period_out(period_out),
    .high_out(high_out),
    .valid(valid),
    .locked(locked),
    .err_sticky(err_sticky),
    .stuck(stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every valid pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst && valid) begin
      vcount++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid #%0d: period_out=%0d high_out=%0d, required no valid",
                 vcount, period_out, high_out);
      end else begin
        e_cur = exp_q.pop_front();
        if (int'(period_out) != e_cur.p || int'(high_out) != e_cur.h ||
            int'(locked) != e_cur.lk || int'(err_sticky) != e_cur.er) begin
          fails++;
          $display("FAIL valid_%0d: got period=%0d high=%0d locked=%0d err=%0d, required period=%0d high=%0d locked=%0d err=%0d",
                   vcount, period_out, high_out, locked, err_sticky,
                   e_cur.p, e_cur.h, e_cur.lk, e_cur.er);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run(input int h, input int l);
    div_in = 1'b1;
    cyc(h);
    div_in = 1'b0;
    cyc(l);
  endtask

  task automatic expect_v(input int p, input int h, input int lk, input int er);
    exp_t e;
    e.p  = p;
    e.h  = h;
    e.lk = lk;
    e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_period"}, int'(period_out), 0);
    chk({tag, "_high"},   int'(high_out), 0);
    chk({tag, "_valid"},  int'(valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err"},    int'(err_sticky), 0);
    chk({tag, "_stuck"},  int'(stuck), 0);
  endtask

  initial begin
    rst             = 1'b0;
    div_in          = 1'b0;
    clear           = 1'b0;
    expected_period = 4'd6;
    cyc(3);
    chk_zero_outputs("reset");
    rst = 1'b1;

    // Long idle before any edge saturates cnt but must not flag stuck
    cyc(20);
    chk("idle_no_stuck", int'(stuck), 0);

    // 3-high/3-low: first rise only arms, lock on the fourth result
    run(3, 3);
    expect_v(6, 3, 0, 0); run(3, 3);
    expect_v(6, 3, 0, 0); run(3, 3);
    expect_v(6, 3, 0, 0); run(3, 3);
    expect_v(6, 3, 1, 0); run(3, 3);
    chk("lock_3_3", int'(locked), 1);

    // Clear away from an edge: flags drop, measurements hold
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_locked", int'(locked), 0);
    chk("clear_hold_period", int'(period_out), 6);
    chk("clear_hold_high", int'(high_out), 3);

    // 2-high/4-low from a fresh start
    run(2, 4);
    expect_v(6, 2, 0, 0); run(2, 4);
    expect_v(6, 2, 0, 0); run(2, 4);
    expect_v(6, 2, 0, 0); run(2, 4);
    expect_v(6, 2, 1, 0); run(2, 4);

    // One period of 9 while locked, then relock at 6
    expect_v(6, 2, 1, 0); run(4, 5);
    expect_v(9, 4, 0, 1); run(3, 3);
    expect_v(6, 3, 0, 1); run(3, 3);
    expect_v(6, 3, 0, 1); run(3, 3);
    expect_v(6, 3, 0, 1); run(3, 3);
    expect_v(6, 3, 1, 1); run(3, 3);
    chk("relock_locked", int'(locked), 1);
    chk("relock_err_kept", int'(err_sticky), 1);

    // Hold low: stuck after 15 cycles without a rise
    cyc(8);
    chk("stuck_not_yet", int'(stuck), 0);
    cyc(12);
    chk("stuck_set", int'(stuck), 1);
    chk("stuck_unlocks", int'(locked), 0);
    run(3, 3);
    chk("stuck_cleared", int'(stuck), 0);
    expect_v(6, 3, 0, 1); run(3, 3);

    // Clear on the same edge as a closing rise
    div_in = 1'b1;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_rise_valid", int'(valid), 0);
    chk("clr_rise_locked", int'(locked), 0);
    chk("clr_rise_err", int'(err_sticky), 0);
    chk("clr_rise_stuck", int'(stuck), 0);
    chk("clr_rise_period", int'(period_out), 6);
    chk("clr_rise_high", int'(high_out), 3);
    div_in = 1'b0;
    cyc(3);

    // Re-arm, measure, then reset in the middle of a high phase
    run(3, 3);
    expect_v(6, 3, 0, 0); run(3, 3);
    expect_v(6, 3, 0, 0);
    div_in = 1'b1;
    cyc(5);
    rst    = 1'b0;
    div_in = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    cyc(3);
    rst = 1'b1;
    cyc(5);
    run(3, 3);
    expect_v(6, 3, 0, 0); run(3, 3);
    cyc(4);

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
